ws_rx_decoder: RTL



---
 rtl/ws_rx_decoder.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ws_rx_decoder.sv
// WS2812-style single-wire receiver: classifies high-pulse widths into bits,
// assembles MSB-first 24-bit GRB words and flags the inter-frame latch gap.
module ws_rx_decoder #(
  parameter int T1_MIN       = 8,
  parameter int HIGH_MAX     = 16,
  parameter int RESET_CYCLES = 600,
  parameter int CNT_W        = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ws_in,
  output logic [23:0] data,
  output logic        data_valid,
  output logic        frame_end,
  output logic [15:0] frame_pixels,
  output logic        err
);

  typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] T1_MIN_C   = CNT_W'(T1_MIN);
  localparam logic [CNT_W-1:0] HIGH_MAX_C = CNT_W'(HIGH_MAX);
  localparam logic [CNT_W-1:0] RESET_C    = CNT_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] ONE_C      = CNT_W'(1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + ONE_C;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (&v) ? v : v + 16'd1;
  endfunction

  logic             s1_q, s2_q, s3_q;
  logic             rise;
  state_t           state_q, state_d;
  logic [CNT_W-1:0] high_cnt_q, high_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic [4:0]       bit_cnt_q, bit_cnt_d;
  logic [23:0]      shift_q, shift_d;
  logic [15:0]      word_cnt_q, word_cnt_d;
  logic [23:0]      data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             frame_end_q, frame_end_d;
  logic [15:0]      frame_pixels_q, frame_pixels_d;
  logic             err_q, err_d;
  logic             bit_v;

  assign rise = s2_q & ~s3_q;

  always_comb begin
    state_d        = state_q;
    high_cnt_d     = high_cnt_q;
    low_cnt_d      = low_cnt_q;
    bit_cnt_d      = bit_cnt_q;
    shift_d        = shift_q;
    word_cnt_d     = word_cnt_q;
    data_d         = data_q;
    data_valid_d   = 1'b0;
    frame_end_d    = 1'b0;
    frame_pixels_d = frame_pixels_q;
    err_d          = 1'b0;
    bit_v          = 1'b0;
    case (state_q)
      // Wait for a full latch gap so the first decoded bit is word-aligned.
      SYNC: begin
        if (!s2_q) begin
          low_cnt_d = sat_inc(low_cnt_q);
          if (low_cnt_d >= RESET_C) state_d = IDLE;
        end else begin
          low_cnt_d = '0;
        end
      end
      IDLE: begin
        if (rise) begin
          state_d    = HIGH;
          high_cnt_d = ONE_C;
        end
      end
      HIGH: begin
        if (s2_q) begin
          high_cnt_d = sat_inc(high_cnt_q);
        end else if (high_cnt_q > HIGH_MAX_C) begin
          err_d     = 1'b1;
          bit_cnt_d = '0;
          low_cnt_d = ONE_C;
          state_d   = SYNC;
        end else begin
          bit_v     = (high_cnt_q >= T1_MIN_C);
          shift_d   = {shift_q[22:0], bit_v};
          if (bit_cnt_q == 5'd23) begin
            data_d       = shift_d;
            data_valid_d = 1'b1;
            bit_cnt_d    = '0;
            word_cnt_d   = sat_inc16(word_cnt_q);
          end else begin
            bit_cnt_d = bit_cnt_q + 5'd1;
          end
          low_cnt_d = ONE_C;
          state_d   = LOW;
        end
      end
      LOW: begin
        if (rise) begin
          state_d    = HIGH;
          high_cnt_d = ONE_C;
        end else begin
          low_cnt_d = sat_inc(low_cnt_q);
          if (low_cnt_d >= RESET_C) begin
            frame_end_d    = 1'b1;
            frame_pixels_d = word_cnt_q;
            word_cnt_d     = '0;
            err_d          = (bit_cnt_q != 5'd0);
            bit_cnt_d      = '0;
            state_d        = IDLE;
          end
        end
      end
      default: state_d = SYNC;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      s3_q           <= 1'b0;
      state_q        <= SYNC;
      high_cnt_q     <= '0;
      low_cnt_q      <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      word_cnt_q     <= '0;
      data_q         <= '0;
      data_valid_q   <= 1'b0;
      frame_end_q    <= 1'b0;
      frame_pixels_q <= '0;
      err_q          <= 1'b0;
    end else begin
      s1_q           <= ws_in;
      s2_q           <= s1_q;
      s3_q           <= s2_q;
      state_q        <= state_d;
      high_cnt_q     <= high_cnt_d;
      low_cnt_q      <= low_cnt_d;
      bit_cnt_q      <= bit_cnt_d;
      shift_q        <= shift_d;
      word_cnt_q     <= word_cnt_d;
      data_q         <= data_d;
      data_valid_q   <= data_valid_d;
      frame_end_q    <= frame_end_d;
      frame_pixels_q <= frame_pixels_d;
      err_q          <= err_d;
    end
  end

  assign data         = data_q;
  assign data_valid   = data_valid_q;
  assign frame_end    = frame_end_q;
  assign frame_pixels = frame_pixels_q;
  assign err          = err_q;

endmodule
